// File: rtl/rect_layer_compositor.sv
// N-layer rectangle compositor for the 640x480 VGA pixel path.
// Double-buffered layer config, fixed priority, 2-cycle registered RGB.
module rect_layer_compositor #(
  parameter int          NUM_RECTS   = 4,
  parameter int          COORD_W     = 16,
  parameter int          H_VIS_START = 144,
  parameter int          H_VIS_END   = 783,
  parameter int          V_VIS_START = 35,
  parameter int          V_VIS_END   = 514,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  localparam int         IDX_W       =
    (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] h_count_value,
  input  logic [COORD_W-1:0] v_count_value,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_h_start,
  input  logic [COORD_W-1:0] cfg_v_start,
  input  logic [COORD_W-1:0] cfg_h_end,
  input  logic [COORD_W-1:0] cfg_v_end,
  input  logic [11:0]        cfg_color,
  input  logic               cfg_enable,
  output logic               commit_pending,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               pix_visible,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx
);

  typedef struct packed {
    logic [COORD_W-1:0] hs;
    logic [COORD_W-1:0] vs;
    logic [COORD_W-1:0] he;
    logic [COORD_W-1:0] ve;
    logic [11:0]        color;
    logic               en;
  } rect_t;

  localparam logic [COORD_W-1:0] HVS = COORD_W'(H_VIS_START);
  localparam logic [COORD_W-1:0] HVE = COORD_W'(H_VIS_END);
  localparam logic [COORD_W-1:0] VVS = COORD_W'(V_VIS_START);
  localparam logic [COORD_W-1:0] VVE = COORD_W'(V_VIS_END);

  rect_t shadow_q [NUM_RECTS];
  rect_t shadow_d [NUM_RECTS];
  rect_t active_q [NUM_RECTS];
  rect_t active_d [NUM_RECTS];

  logic                 pend_q, pend_d;
  logic                 wr_ok, commit;
  logic [NUM_RECTS-1:0] hitv_q, hitv_d;
  logic                 vis1_q, vis1_d;
  logic [11:0]          rgb_q, rgb_d;
  logic                 vis2_q, vis2_d;
  logic                 hit2_q, hit2_d;
  logic [IDX_W-1:0]     idx2_q, idx2_d;
  logic [IDX_W-1:0]     win;
  logic [11:0]          win_col;
  logic                 any_hit;

  // Config path: out-of-range indices match no slot and are dropped.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    wr_ok    = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (cfg_we && cfg_idx == IDX_W'(i)) begin
        shadow_d[i] = {cfg_h_start, cfg_v_start, cfg_h_end,
                       cfg_v_end, cfg_color, cfg_enable};
        wr_ok = 1'b1;
      end
    end
    commit = pend_q && h_count_value == '0 && v_count_value == '0;
    // Commit takes the pre-write shadow; a same-cycle write stays pending.
    if (commit) active_d = shadow_q;
    pend_d = pend_q;
    if (commit) pend_d = 1'b0;
    if (wr_ok)  pend_d = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_RECTS; i++) begin
      hitv_d[i] = active_q[i].en
        && h_count_value >= active_q[i].hs
        && h_count_value <= active_q[i].he
        && v_count_value >= active_q[i].vs
        && v_count_value <= active_q[i].ve;
    end
    vis1_d = h_count_value >= HVS && h_count_value <= HVE
          && v_count_value >= VVS && v_count_value <= VVE;
  end

  // Ascending scan so the highest set index ends up winning.
  always_comb begin
    win     = '0;
    win_col = BG_COLOR;
    any_hit = |hitv_q;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (hitv_q[i]) begin
        win     = IDX_W'(i);
        win_col = active_q[i].color;
      end
    end
    rgb_d  = 12'h000;
    vis2_d = vis1_q;
    hit2_d = 1'b0;
    idx2_d = '0;
    if (vis1_q) begin
      rgb_d  = win_col;
      hit2_d = any_hit;
      idx2_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pend_q <= 1'b0;
      hitv_q <= '0;
      vis1_q <= 1'b0;
      rgb_q  <= '0;
      vis2_q <= 1'b0;
      hit2_q <= 1'b0;
      idx2_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      hitv_q   <= hitv_d;
      vis1_q   <= vis1_d;
      rgb_q    <= rgb_d;
      vis2_q   <= vis2_d;
      hit2_q   <= hit2_d;
      idx2_q   <= idx2_d;
    end
  end

  assign commit_pending = pend_q;
  assign red            = rgb_q[11:8];
  assign green          = rgb_q[7:4];
  assign blue           = rgb_q[3:0];
  assign pix_visible    = vis2_q;
  assign hit            = hit2_q;
  assign hit_idx        = idx2_q;

endmodule

// File: tb/tb_rect_layer_compositor.sv
// Directed bench for rect_layer_compositor.
// Each pixel check is followed by a junk count to pin the 2-cycle latency.
module tb_rect_layer_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] h_cnt, v_cnt;
  logic        cfg_we, cfg_we5;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_idx5;
  logic [15:0] c_hs, c_vs, c_he, c_ve;
  logic [11:0] c_col;
  logic        c_en;
  logic        pend, vis, hit;
  logic [3:0]  r, g, b;
  logic [1:0]  hidx;
  logic        pend5, vis5, hit5;
  logic [3:0]  r5, g5, b5;
  logic [2:0]  hidx5;
  int          vecs = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  rect_layer_compositor dut (
    .clk(clk), .rst(rst),
    .h_count_value(h_cnt), .v_count_value(v_cnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_h_start(c_hs), .cfg_v_start(c_vs),
    .cfg_h_end(c_he), .cfg_v_end(c_ve),
    .cfg_color(c_col), .cfg_enable(c_en),
    .commit_pending(pend),
    .red(r), .green(g), .blue(b),
    .pix_visible(vis), .hit(hit), .hit_idx(hidx)
  );

  rect_layer_compositor #(.NUM_RECTS(5)) u5 (
    .clk(clk), .rst(rst),
    .h_count_value(h_cnt), .v_count_value(v_cnt),
    .cfg_we(cfg_we5), .cfg_idx(cfg_idx5),
    .cfg_h_start(c_hs), .cfg_v_start(c_vs),
    .cfg_h_end(c_he), .cfg_v_end(c_ve),
    .cfg_color(c_col), .cfg_enable(c_en),
    .commit_pending(pend5),
    .red(r5), .green(g5), .blue(b5),
    .pix_visible(vis5), .hit(hit5), .hit_idx(hidx5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hv(input int h, input int v);
    h_cnt = 16'(h);
    v_cnt = 16'(v);
  endtask

  function automatic logic [15:0] pk(input logic ev, input logic eh,
                                     input logic [1:0] ei,
                                     input logic [11:0] ec);
    return {ev, eh, ei, ec};
  endfunction

  task automatic cmp(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {vis, hit, hidx, r, g, b};
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got vis/hit/idx/rgb=%h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int h, input int v,
                     input logic [15:0] exp);
    set_hv(h, v);
    tick();
    set_hv(1, 1);
    tick();
    cmp(tag, exp);
  endtask

  task automatic chkp(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got pending=%b want %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int hs, input int vs,
                    input int he, input int ve,
                    input logic [11:0] col, input logic en);
    cfg_idx = 2'(idx);
    c_hs = 16'(hs); c_vs = 16'(vs);
    c_he = 16'(he); c_ve = 16'(ve);
    c_col = col; c_en = en;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic frame();
    set_hv(0, 0);
    tick();
    set_hv(1, 1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_we5 = 1'b0;
    cfg_idx = '0; cfg_idx5 = '0;
    c_hs = '0; c_vs = '0; c_he = '0; c_ve = '0;
    c_col = '0; c_en = 1'b0;
    set_hv(1, 1);
    tick();
    tick();
    cmp("reset_out", 16'h0000);
    chkp("reset_pend", pend, 1'b0);
    rst = 1'b0;

    // Empty frame: sub-sampled sweep, visible pixels are background.
    for (int v = 0; v < 525; v += 53) begin
      for (int h = 0; h < 800; h += 41) begin
        logic ev;
        ev = (h >= 144 && h <= 783 && v >= 35 && v <= 514);
        chk($sformatf("sweep_%0d_%0d", h, v), h, v,
            pk(ev, 1'b0, 2'd0, 12'h000));
      end
    end
    chk("edge_143_100", 143, 100, pk(0, 0, 0, 12'h000));
    chk("edge_144_100", 144, 100, pk(1, 0, 0, 12'h000));
    chk("edge_783_514", 783, 514, pk(1, 0, 0, 12'h000));
    chk("edge_784_100", 784, 100, pk(0, 0, 0, 12'h000));
    chk("edge_200_34", 200, 34, pk(0, 0, 0, 12'h000));
    chk("edge_200_515", 200, 515, pk(0, 0, 0, 12'h000));

    // Mid-frame write stays in shadow until frame start.
    set_hv(400, 240);
    wr(0, 150, 50, 300, 200, 12'hF00, 1'b1);
    set_hv(1, 1);
    chkp("s2_pend_set", pend, 1'b1);
    chk("s2_pre_commit", 150, 50, pk(1, 0, 0, 12'h000));
    frame();
    chkp("s2_pend_clr", pend, 1'b0);
    chk("s2_tl", 150, 50, pk(1, 1, 0, 12'hF00));
    chk("s2_br", 300, 200, pk(1, 1, 0, 12'hF00));
    chk("s2_right", 301, 50, pk(1, 0, 0, 12'h000));
    chk("s2_left", 149, 50, pk(1, 0, 0, 12'h000));
    chk("s2_above", 150, 49, pk(1, 0, 0, 12'h000));

    // Overlap priority.
    wr(3, 200, 100, 400, 300, 12'h00F, 1'b1);
    frame();
    chk("s3_overlap", 250, 150, pk(1, 1, 3, 12'h00F));
    chk("s3_l0_only", 160, 60, pk(1, 1, 0, 12'hF00));
    chk("s3_l3_only", 350, 250, pk(1, 1, 3, 12'h00F));

    // Write in the commit cycle stays pending one more frame.
    wr(2, 500, 400, 600, 450, 12'h0F0, 1'b1);
    chkp("s4_pend_pre", pend, 1'b1);
    set_hv(0, 0);
    cfg_idx = 2'd1;
    c_hs = 16'd600; c_vs = 16'd300;
    c_he = 16'd700; c_ve = 16'd350;
    c_col = 12'h0FF; c_en = 1'b1;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    set_hv(1, 1);
    chkp("s4_pend_after", pend, 1'b1);
    chk("s4_l2_active", 550, 420, pk(1, 1, 2, 12'h0F0));
    chk("s4_l1_inactive", 650, 320, pk(1, 0, 0, 12'h000));
    frame();
    chkp("s4_pend_clr", pend, 1'b0);
    chk("s4_l1_active", 650, 320, pk(1, 1, 1, 12'h0FF));

    // Degenerate geometry.
    wr(2, 500, 35, 400, 514, 12'h0F0, 1'b1);
    wr(1, 200, 35, 200, 514, 12'hFF0, 1'b1);
    frame();
    chk("s5_inv_450", 450, 100, pk(1, 0, 0, 12'h000));
    chk("s5_inv_500", 500, 100, pk(1, 0, 0, 12'h000));
    chk("s5_inv_400", 400, 400, pk(1, 0, 0, 12'h000));
    chk("s5_line_top", 200, 35, pk(1, 1, 1, 12'hFF0));
    chk("s5_line_bot", 200, 514, pk(1, 1, 1, 12'hFF0));
    chk("s5_line_l", 199, 35, pk(1, 0, 0, 12'h000));
    chk("s5_line_r", 201, 35, pk(1, 0, 0, 12'h000));
    chk("s5_prio3", 200, 150, pk(1, 1, 3, 12'h00F));
    cfg_idx5 = 3'd5;
    cfg_we5 = 1'b1;
    tick();
    cfg_idx5 = 3'd7;
    tick();
    cfg_we5 = 1'b0;
    chkp("s5_idx_oob", pend5, 1'b0);
    cfg_idx5 = 3'd4;
    cfg_we5 = 1'b1;
    tick();
    cfg_we5 = 1'b0;
    chkp("s5_idx_last", pend5, 1'b1);

    // Reset mid-frame with active layers.
    wr(0, 10, 10, 20, 20, 12'h123, 1'b1);
    set_hv(250, 150);
    tick();
    set_hv(300, 100);
    tick();
    cmp("s6_pre_rst", pk(1, 1, 3, 12'h00F));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("s6_rst_out", 16'h0000);
    chkp("s6_rst_pend", pend, 1'b0);
    set_hv(1, 1);
    tick();
    chk("s6_bg_a", 250, 150, pk(1, 0, 0, 12'h000));
    frame();
    chk("s6_bg_b", 160, 60, pk(1, 0, 0, 12'h000));
    chk("s6_bg_c", 650, 320, pk(1, 0, 0, 12'h000));
    chkp("s6_pend", pend, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule
